// File: rtl/membrane_update_if.sv
// Neuron timestep bus: per-step inputs and registered membrane/spike outputs.
// master drives the timestep, slave is the membrane update block.
interface membrane_update_if #(
    parameter int WIDTH        = 6,
    parameter int REFRAC_WIDTH = 3
);
    logic                      in_valid;
    logic signed [WIDTH-1:0]   u_bn;
    logic [WIDTH-2:0]          threshold;
    logic [2:0]                leak_shift;
    logic                      reset_mode;
    logic [REFRAC_WIDTH-1:0]   refrac_period;
    logic                      count_clear;

    logic signed [WIDTH-1:0]   u;
    logic                      spike;
    logic                      out_valid;
    logic                      refractory;
    logic [7:0]                spike_count;

    modport master (
        output in_valid, u_bn, threshold, leak_shift, reset_mode, refrac_period, count_clear,
        input  u, spike, out_valid, refractory, spike_count
    );

    modport slave (
        input  in_valid, u_bn, threshold, leak_shift, reset_mode, refrac_period, count_clear,
        output u, spike, out_valid, refractory, spike_count
    );
endinterface

// File: rtl/membrane_update.sv
// Leaky integrate-and-fire membrane update with refractory FSM and spike counter.
// One-cycle latency from in_valid; no backpressure, every valid timestep is consumed.
module membrane_update #(
    parameter int WIDTH        = 6,
    parameter int REFRAC_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    membrane_update_if.slave   bus
);
    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [REFRAC_WIDTH-1:0]   cnt, cnt_nxt;
    logic signed [WIDTH-1:0]   u_reg, u_nxt;
    logic                      spike_reg, spike_nxt;
    logic                      out_valid_reg;
    logic [7:0]                count_reg, count_nxt;

    logic signed [WIDTH:0]     u_ext;
    logic signed [WIDTH:0]     thr_ext;
    logic signed [WIDTH:0]     leak_amt;
    logic signed [WIDTH:0]     leaked;
    logic                      fire;

    // One extra bit keeps u_bn - (u_bn >>> s) free of overflow for every u_bn.
    always_comb begin
        u_ext    = {bus.u_bn[WIDTH-1], bus.u_bn};
        thr_ext  = {2'b00, bus.threshold};
        leak_amt = '0;
        if (bus.leak_shift != 3'd0 && 32'(bus.leak_shift) < WIDTH)
            leak_amt = u_ext >>> bus.leak_shift;
        leaked = u_ext - leak_amt;
        fire   = (leaked >= thr_ext);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        u_nxt     = u_reg;
        spike_nxt = 1'b0;
        count_nxt = count_reg;
        if (bus.in_valid) begin
            if (state == INTEGRATE) begin
                if (fire) begin
                    spike_nxt = 1'b1;
                    u_nxt     = bus.reset_mode ? WIDTH'(leaked - thr_ext) : '0;
                    if (count_reg != 8'hFF)
                        count_nxt = count_reg + 8'd1;
                    if (bus.refrac_period != '0) begin
                        state_nxt = REFRACT;
                        cnt_nxt   = bus.refrac_period;
                    end
                end else begin
                    u_nxt = WIDTH'(leaked);
                end
            end else begin
                cnt_nxt = cnt - REFRAC_WIDTH'(1);
                if (cnt == REFRAC_WIDTH'(1))
                    state_nxt = INTEGRATE;
            end
        end
        if (bus.count_clear)
            count_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INTEGRATE;
            cnt           <= '0;
            u_reg         <= '0;
            spike_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            u_reg         <= u_nxt;
            spike_reg     <= spike_nxt;
            out_valid_reg <= bus.in_valid;
            count_reg     <= count_nxt;
        end
    end

    assign bus.u           = u_reg;
    assign bus.spike       = spike_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.refractory  = (state == REFRACT);
    assign bus.spike_count = count_reg;
endmodule
